// File: rtl/adder_sweep_checker_if.sv
// Operand/result and status bundle between the sweep checker and its environment.
// Combinational only: the checker drives operands and status, and the environment drives start and sum_in.
// No flow control: start is a one-cycle pulse, and sum_in is a level sampled by the checker.
interface adder_sweep_checker_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [16:0]      pair_count;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic [WIDTH-1:0] first_err_sum;

  // checker side
  modport master (
    input  start, sum_in,
    output a_out, b_out, busy, done, pass, err_count, pair_count,
           first_err_a, first_err_b, first_err_sum
  );

  // environment side (stimulus source / adder under test)
  modport slave (
    output start, sum_in,
    input  a_out, b_out, busy, done, pass, err_count, pair_count,
           first_err_a, first_err_b, first_err_sum
  );
endinterface

// File: rtl/adder_sweep_checker.sv
// Exhaustive operand sweep and sum checker for a WIDTH-bit combinational adder.
// Each pair takes SETTLE_CYCLES+1 clocks, so a full sweep takes 2^(2*WIDTH)*(SETTLE_CYCLES+1) clocks from the start edge to done.
// No backpressure: start is ignored while busy, and sum_in is sampled unconditionally in CHECK.
module adder_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_sweep_checker_if.master bus
);

  localparam logic [WIDTH-1:0] OPND_MAX  = '1;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [15:0]      err_nxt;
  logic             last_pair;

  // Expected modulo sum for the operands currently driven, and the saturating error count after this check
  always_comb begin
    expected  = bus.a_out + bus.b_out;
    mismatch  = (bus.sum_in != expected);
    err_nxt   = bus.err_count;
    if (mismatch && (bus.err_count != 16'hFFFF)) begin
      err_nxt = bus.err_count + 16'd1;
    end
    last_pair = (bus.a_out == OPND_MAX) && (bus.b_out == OPND_MAX);
  end

  // Sweep FSM: settle wait, single-cycle check, and operand stepping; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      settle_cnt        <= 4'd0;
      bus.a_out         <= '0;
      bus.b_out         <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.err_count     <= 16'd0;
      bus.pair_count    <= 17'd0;
      bus.first_err_a   <= '0;
      bus.first_err_b   <= '0;
      bus.first_err_sum <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.a_out         <= '0;
            bus.b_out         <= '0;
            bus.err_count     <= 16'd0;
            bus.pair_count    <= 17'd0;
            bus.first_err_a   <= '0;
            bus.first_err_b   <= '0;
            bus.first_err_sum <= '0;
            bus.done          <= 1'b0;
            bus.pass          <= 1'b0;
            bus.busy          <= 1'b1;
            settle_cnt        <= SETTLE_LD;
            state             <= SETTLE;
          end
        end

        SETTLE: begin
          // The count of 1 is the final settle cycle, so SETTLE_CYCLES=1 gives exactly one SETTLE cycle
          if (settle_cnt <= 4'd1) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        CHECK: begin
          bus.err_count  <= err_nxt;
          bus.pair_count <= bus.pair_count + 17'd1;
          if (mismatch && (bus.err_count == 16'd0)) begin
            bus.first_err_a   <= bus.a_out;
            bus.first_err_b   <= bus.b_out;
            bus.first_err_sum <= bus.sum_in;
          end
          if (last_pair) begin
            // Operands hold at all-ones so the last pair stays visible after completion
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_nxt == 16'd0);
            state    <= DONE;
          end else begin
            bus.b_out <= bus.b_out + 1'b1;
            if (bus.b_out == OPND_MAX) begin
              bus.a_out <= bus.a_out + 1'b1;
            end
            settle_cnt <= SETTLE_LD;
            state      <= SETTLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker with good, stuck-bit, single-fault and delayed adder models.
// Sweep length is checked in clocks from the start edge to the edge that raises done.
// Status is sampled 1 time unit after the rising edge, and start is driven on the falling edge.
module tb_adder_sweep_checker;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  int   mode;   // 0 = correct, 1 = sum bit0 stuck at 0, 2 = +1 only at a=3,b=8

  adder_sweep_checker_if #(.WIDTH(4)) bus    ();
  adder_sweep_checker_if #(.WIDTH(2)) bus_s3 ();
  adder_sweep_checker_if #(.WIDTH(2)) bus_s1 ();

  adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  adder_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s3)
  );
  adder_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit adder model with selectable faults
  logic [3:0] adder_z;
  always_comb begin
    adder_z = bus.a_out + bus.b_out;
    if (mode == 1) adder_z[0] = 1'b0;
    if (mode == 2 && bus.a_out == 4'd3 && bus.b_out == 4'd8) adder_z = adder_z + 4'd1;
  end
  assign bus.sum_in = adder_z;

  // 2-bit adders whose result lags the operands by two clocks
  logic [1:0] s3_d1, s3_d2, s1_d1, s1_d2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_d1 <= 2'd0; s3_d2 <= 2'd0; s1_d1 <= 2'd0; s1_d2 <= 2'd0;
    end else begin
      s3_d1 <= bus_s3.a_out + bus_s3.b_out;
      s3_d2 <= s3_d1;
      s1_d1 <= bus_s1.a_out + bus_s1.b_out;
      s1_d2 <= s1_d1;
    end
  end
  assign bus_s3.sum_in = s3_d2;
  assign bus_s1.sum_in = s1_d2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       bus.start    = v;
      1:       bus_s3.start = v;
      default: bus_s1.start = v;
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return bus.done;
      1:       return bus_s3.done;
      default: return bus_s1.done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return bus.busy;
      1:       return bus_s3.busy;
      default: return bus_s1.busy;
    endcase
  endfunction

  // Pulse start, then count edges until done; optionally re-pulse start mid-sweep
  task automatic run_sweep(input int sel, input int ign_at, output int cycles);
    int busy_gaps;
    busy_gaps = 0;
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk); #1; set_start(sel, 1'b0);
    chk("start_done_clr", 32'(done_of(sel)), 32'd0);
    chk("start_busy", 32'(busy_of(sel)), 32'd1);
    cycles = 0;
    while (!done_of(sel) && cycles < 2000) begin
      @(negedge clk); set_start(sel, cycles == ign_at);
      @(posedge clk); #1; set_start(sel, 1'b0);
      cycles++;
      if (!done_of(sel) && !busy_of(sel)) busy_gaps++;
    end
    chk("sweep_done", 32'(done_of(sel)), 32'd1);
    chk("busy_after_done", 32'(busy_of(sel)), 32'd0);
    chk("busy_gaps", 32'(busy_gaps), 32'd0);
  endtask

  task automatic chk_result(input string tag, input logic pass_e, input int err_e,
                            input int fa, input int fb, input int fs);
    chk({tag, "_pass"},  32'(bus.pass), 32'(pass_e));
    chk({tag, "_err"},   32'(bus.err_count), 32'(err_e));
    chk({tag, "_pairs"}, 32'(bus.pair_count), 32'd256);
    chk({tag, "_fa"},    32'(bus.first_err_a), 32'(fa));
    chk({tag, "_fb"},    32'(bus.first_err_b), 32'(fb));
    chk({tag, "_fs"},    32'(bus.first_err_sum), 32'(fs));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},    32'(bus.a_out), 32'd0);
    chk({tag, "_b"},    32'(bus.b_out), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_err"},  32'(bus.err_count), 32'd0);
    chk({tag, "_pairs"}, 32'(bus.pair_count), 32'd0);
    chk({tag, "_fe"},   32'({bus.first_err_a, bus.first_err_b, bus.first_err_sum}), 32'd0);
  endtask

  initial begin
    int cyc;
    n_vec = 0; n_bad = 0; mode = 0;
    bus.start = 1'b0; bus_s3.start = 1'b0; bus_s1.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    chk("rst_s3_busy", 32'(bus_s3.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start_busy", 32'(bus.busy), 32'd0);

    // correct adder
    mode = 0;
    run_sweep(0, -1, cyc);
    chk("good_cycles", 32'(cyc), 32'd512);
    chk_result("good", 1'b1, 0, 0, 0, 0);
    chk("good_a_hold", 32'(bus.a_out), 32'hF);
    chk("good_b_hold", 32'(bus.b_out), 32'hF);

    // sum bit 0 stuck at 0
    mode = 1;
    run_sweep(0, -1, cyc);
    chk("stuck_cycles", 32'(cyc), 32'd512);
    chk_result("stuck", 1'b0, 128, 0, 1, 0);

    // single faulty pair, start re-pulsed mid-sweep
    mode = 2;
    run_sweep(0, 100, cyc);
    chk("single_cycles", 32'(cyc), 32'd512);
    chk_result("single", 1'b0, 1, 3, 8, 4'hC);

    // start from DONE: repeat gives identical results
    run_sweep(0, -1, cyc);
    chk("repeat_cycles", 32'(cyc), 32'd512);
    chk_result("repeat", 1'b0, 1, 3, 8, 4'hC);

    // asynchronous reset mid-sweep, then a fresh sweep
    mode = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (199) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk_all_zero("midrst_hold");
    @(negedge clk); rst_n = 1'b1;
    run_sweep(0, -1, cyc);
    chk("after_rst_cycles", 32'(cyc), 32'd512);
    chk_result("after_rst", 1'b1, 0, 0, 0, 0);

    // delayed adder, WIDTH=2: SETTLE_CYCLES=3 tolerates the lag, SETTLE_CYCLES=1 does not
    run_sweep(1, -1, cyc);
    chk("s3_cycles", 32'(cyc), 32'd64);
    chk("s3_pairs", 32'(bus_s3.pair_count), 32'd16);
    chk("s3_pass", 32'(bus_s3.pass), 32'd1);
    chk("s3_err", 32'(bus_s3.err_count), 32'd0);
    run_sweep(2, -1, cyc);
    chk("s1_cycles", 32'(cyc), 32'd32);
    chk("s1_pairs", 32'(bus_s1.pair_count), 32'd16);
    chk("s1_pass", 32'(bus_s1.pass), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
